// File: rtl/acc_cpu_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle accumulator CPU.
package acc_cpu_pkg;

    localparam int unsigned OPC_W = 8;

    localparam logic [OPC_W-1:0] OP_LOAD  = 8'h00;
    localparam logic [OPC_W-1:0] OP_ADD   = 8'h01;
    localparam logic [OPC_W-1:0] OP_SUB   = 8'h02;
    localparam logic [OPC_W-1:0] OP_DIV   = 8'h03;
    localparam logic [OPC_W-1:0] OP_MUL   = 8'h04;
    localparam logic [OPC_W-1:0] OP_OUT   = 8'h05;
    localparam logic [OPC_W-1:0] OP_READ  = 8'h06;
    localparam logic [OPC_W-1:0] OP_SAVE  = 8'h07;
    localparam logic [OPC_W-1:0] OP_SCAN  = 8'h08;
    localparam logic [OPC_W-1:0] OP_INC   = 8'h09;
    localparam logic [OPC_W-1:0] OP_DEC   = 8'h0A;
    localparam logic [OPC_W-1:0] OP_SHIFT = 8'h0B;
    localparam logic [OPC_W-1:0] OP_SKIP  = 8'h0C;
    localparam logic [OPC_W-1:0] OP_HALT  = 8'h0F;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXEC    = 2'd1,
        WAIT_IN = 2'd2,
        HALT    = 2'd3
    } state_t;

endpackage

// File: rtl/acc_cpu_ram.sv
// Data RAM: synchronous write, asynchronous read, contents never reset.
module acc_cpu_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock_write,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock_write) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/acc_cpu_fsm.sv
// Multi-cycle accumulator CPU: fetch/execute FSM, handshaked input port,
// pulsed output port, HALT and a sticky divide-by-zero flag.
module acc_cpu_fsm
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OP_W   = 8
) (
    input  logic                   clock_write,
    input  logic                   reset,
    output logic [ADDR_W-1:0]      instr_addr,
    input  logic [OP_W+ADDR_W-1:0] instr_data,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      acc_out,
    output logic                   halted,
    output logic                   err_div0
);

    localparam int unsigned INSTR_W = OP_W + ADDR_W;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                halted_q, halted_d;
    logic                err_q, err_d;

    logic [OP_W-1:0]     op;
    logic [ADDR_W-1:0]   opnd;
    logic [DATA_W-1:0]   mem_rd;
    logic                ram_we;

    assign op   = ir_q[INSTR_W-1 -: OP_W];
    assign opnd = ir_q[ADDR_W-1:0];

    // A SAVE whose EXEC edge coincides with reset must not reach the RAM.
    assign ram_we = (state_q == EXEC) && (op == OP_W'(OP_SAVE)) && !reset;

    acc_cpu_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock_write (clock_write),
        .we          (ram_we),
        .addr        (opnd),
        .wdata       (acc_q),
        .rdata_c     (mem_rd)
    );

    always_ff @(posedge clock_write) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            halted_q    <= halted_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        acc_d       = acc_q;
        ir_d        = ir_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        in_ready_d  = in_ready_q;
        halted_d    = halted_q;
        err_d       = err_q;

        case (state_q)
            FETCH: begin
                ir_d    = instr_data;
                state_d = EXEC;
            end

            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + ADDR_W'(1);
                case (op)
                    OP_W'(OP_LOAD): acc_d = mem_rd;
                    OP_W'(OP_ADD):  acc_d = acc_q + mem_rd;
                    OP_W'(OP_SUB):  acc_d = acc_q - mem_rd;
                    OP_W'(OP_DIV): begin
                        if (mem_rd == '0) begin
                            err_d = 1'b1;
                        end else begin
                            acc_d = acc_q / mem_rd;
                        end
                    end
                    OP_W'(OP_MUL):  acc_d = acc_q * mem_rd;
                    OP_W'(OP_OUT): begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_W'(OP_READ): begin
                        pc_d       = pc_q;
                        in_ready_d = 1'b1;
                        state_d    = WAIT_IN;
                    end
                    OP_W'(OP_SCAN):  acc_d = DATA_W'(opnd);
                    OP_W'(OP_INC):   acc_d = acc_q + DATA_W'(1);
                    OP_W'(OP_DEC):   acc_d = acc_q - DATA_W'(1);
                    OP_W'(OP_SHIFT): pc_d  = pc_q - ADDR_W'(acc_q);
                    OP_W'(OP_SKIP): begin
                        if (acc_q == '0) begin
                            pc_d = pc_q + ADDR_W'(3);
                        end
                    end
                    OP_W'(OP_HALT): begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
                    default: ;
                endcase
            end

            WAIT_IN: begin
                if (in_valid && in_ready_q) begin
                    acc_d      = in_data;
                    pc_d       = pc_q + ADDR_W'(1);
                    in_ready_d = 1'b0;
                    state_d    = FETCH;
                end
            end

            HALT: ;

            default: state_d = FETCH;
        endcase
    end

    assign instr_addr = pc_q;
    assign acc_out    = acc_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign halted     = halted_q;
    assign err_div0   = err_q;

endmodule

// File: doc/acc_cpu_fsm.md
Name: acc_cpu_fsm

Overview:
Parametrised, multi-cycle accumulator CPU. It is the next generation of the team's single-cycle accumulator core, generalised in data and address width.
- Adds an explicit fetch/execute FSM, a ready/valid handshake on the input port, a validated output port, HALT, and a sticky divide-by-zero flag.
- Program memory is external (instr_addr/instr_data). Data RAM is internal.

Parameters:
DATA_W, 8, accumulator/RAM/port data width
ADDR_W, 8, PC and operand width; RAM depth = 2**ADDR_W
OP_W, 8, opcode field width; instruction = {opcode[OP_W], operand[ADDR_W]}

Ports:
clock_write  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
instr_addr  out  ADDR_W  program address (= pc)
instr_data  in  OP_W+ADDR_W  instruction word, combinational response to instr_addr
in_data  in  DATA_W  input port data
in_valid  in  1  in_data valid
in_ready  out  1  CPU accepts in_data (READ pending)
out_data  out  DATA_W  last value emitted by OUT
out_valid  out  1  one-cycle pulse per OUT
acc_out  out  DATA_W  accumulator
halted  out  1  HALT executed
err_div0  out  1  sticky divide-by-zero flag

Behaviour:
Interface:
- reset reset, synchronous, active-high; clock clock_write.

Reset (synchronous, checked at clock_write edge, any state, including mid-WAIT_IN):
- pc=0, acc=0, state=FETCH.
- out_data=0, out_valid=0, in_ready=0, halted=0, err_div0=0.
- RAM contents are not reset. Reading an unwritten location returns X; benches SAVE before LOAD.

FSM states: FETCH, EXEC, WAIT_IN, HALT.
- FETCH: instr_addr=pc; instr_data latched into ir at edge; -> EXEC.
- EXEC: execute ir; -> FETCH. Exceptions: READ -> WAIT_IN; HALT -> HALT.
- Normal instruction = 2 cycles.
- WAIT_IN:
  - in_ready=1 (registered, high whole state).
  - On in_valid&&in_ready: acc<=in_data, pc<=pc+1, -> FETCH.
  - Otherwise pc and acc hold.
- HALT:
  - halted=1; instr_addr frozen at the HALT address + 1.
  - Leaves only via reset.

Opcodes (operand = a; mem = RAM[a]); all non-jump ops do pc<=pc+1:
- 00 LOAD: acc=mem
- 01 ADD: acc=acc+mem
- 02 SUB: acc=acc-mem
- 03 DIV: acc=acc/mem (unsigned). If mem==0: acc unchanged, err_div0<=1.
- 04 MUL: acc=low DATA_W bits of acc*mem
- 05 OUT: out_data<=acc; out_valid=1 for exactly the next cycle
- 06 READ: enter WAIT_IN
- 07 SAVE: RAM[a]<=acc at EXEC edge
- 08 SCAN: acc=a zero-extended/truncated to DATA_W
- 09 INC: acc=acc+1
- 0A DEC: acc=acc-1
- 0B SHIFT: pc<=pc-acc[ADDR_W-1:0]
- 0C SKIP: pc<=(acc==0)?pc+3:pc+1
- 0F HALT
- Any other opcode: NOP

Arithmetic and wrap rules:
- All arithmetic is unsigned and wraps modulo 2**DATA_W.
- pc arithmetic wraps modulo 2**ADDR_W (0xFF+1 -> 0x00).

Timing details:
- RAM read is combinational from ir operand during EXEC.
- A SAVE followed by a LOAD of the same address returns the new value (write completes before the next EXEC).
- out_valid is low in all cycles other than the pulse.
- err_div0 clears only on reset.

Decomposition:
- Package acc_cpu_pkg: opcode localparams (LOAD..HALT), state_t enum {FETCH, EXEC, WAIT_IN, HALT}.
- Sub-module acc_cpu_ram: parametrised (DATA_W, ADDR_W) RAM, sync write on clock_write, async read, no reset.

Test Plan:
1. Program SCAN 5; SAVE 10; SCAN 3; ADD 10; OUT 0; HALT -> exactly one out_valid pulse with out_data=8. halted=1 at cycle 12 after reset release. instr_addr stays 6.
2. Program SCAN 7; SAVE 1; SCAN 0; SAVE 2; SCAN 7; DIV 2 -> acc_out=7, err_div0=1 and held. Then reset -> err_div0=0, acc_out=0.
3. READ with in_valid low for 4 cycles -> in_ready=1 throughout, instr_addr/acc frozen. Then in_valid=1, in_data=0xA5 -> acc_out=0xA5, in_ready=0 next cycle, FETCH of pc+1.
4. SKIP at pc=4 with acc=0 -> next fetch pc=7; with acc=2 -> pc=5. SHIFT at pc=5 with acc=2 -> next fetch pc=3.
5. Width/wrap:
   - DATA_W=8: RAM[1]=0x20, acc=0x10, MUL 1 -> acc=0x00.
   - INC from 0xFF -> 0x00.
   - NOP at pc=0xFF -> next pc=0x00.
   - Rerun scenario 1 with DATA_W=16, ADDR_W=10 -> out_data=8.
6. Assert reset during WAIT_IN and during EXEC of SAVE -> all outputs at reset values next cycle, in_ready=0, fetch restarts at 0. A SAVE interrupted by reset does not write RAM.
